// File: rtl/not_bist_ctrl.sv
// ---------------------------------------------------------------------------
// not_bist_ctrl
//   Built-in self-test sequencer for a single inverter. Applies NUM_VECTORS
//   alternating vectors (0,1,0,1,...) to the inverter input, waits SETTLE
//   cycles per vector, then compares the inverter output against ~dut_a.
//   Mismatches are counted (saturating) and the first failing index is kept.
//
// Parameters
//   NUM_VECTORS : vectors per run (1..16)
//   SETTLE      : wait cycles between drive and check (0..15)
//   CNT_W       : width of the mismatch counter
//
// Ports
//   clk            : single clock, rising edge
//   rst            : synchronous active-high reset
//   start          : run request, honoured only in IDLE and DONE
//   dut_a          : registered drive to the inverter input
//   dut_out        : inverter output, sampled only in CHECK
//   busy           : high in DRIVE, SETTLE and CHECK
//   done           : high while in DONE
//   pass           : high in DONE when no mismatch was seen
//   err_cnt        : mismatch count of the current or last run
//   fail_valid     : at least one mismatch recorded this run
//   first_fail_idx : index of the first mismatching vector
// ---------------------------------------------------------------------------
module not_bist_ctrl #(
  parameter int NUM_VECTORS = 6,
  parameter int SETTLE      = 2,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             dut_a,
  input  logic             dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_cnt,
  output logic             fail_valid,
  output logic [3:0]       first_fail_idx
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam logic [3:0]       LAST_IDX  = 4'(NUM_VECTORS - 1);
  localparam logic [3:0]       SETTLE_LD = 4'(SETTLE);
  localparam logic [CNT_W-1:0] ERR_MAX   = '1;

  state_t           state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic [3:0]       settle_q, settle_d;
  logic             dut_a_q, dut_a_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic             fv_q, fv_d;
  logic [3:0]       ffi_q, ffi_d;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    settle_d = settle_q;
    dut_a_d  = dut_a_q;
    err_d    = err_q;
    fv_d     = fv_q;
    ffi_d    = ffi_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        // IDLE keeps the inverter input low; DONE leaves the last vector on it.
        if (state_q == ST_IDLE) dut_a_d = 1'b0;
        if (start) begin
          state_d  = ST_DRIVE;
          idx_d    = 4'd0;
          settle_d = 4'd0;
          dut_a_d  = 1'b0;  // vector 0 has value idx[0] = 0
          err_d    = '0;
          fv_d     = 1'b0;
          ffi_d    = 4'd0;
        end
      end

      ST_DRIVE: begin
        if (SETTLE_LD == 4'd0) begin
          state_d = ST_CHECK;
        end else begin
          state_d  = ST_SETTLE;
          settle_d = SETTLE_LD;
        end
      end

      ST_SETTLE: begin
        // Counter is loaded with SETTLE on entry; leave on the cycle it reads 1
        // so the state lasts exactly SETTLE cycles.
        if (settle_q <= 4'd1) begin
          state_d  = ST_CHECK;
          settle_d = 4'd0;
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end

      ST_CHECK: begin
        if (dut_out != ~dut_a_q) begin
          if (err_q != ERR_MAX) err_d = err_q + CNT_W'(1);
          if (!fv_q) begin
            fv_d  = 1'b1;
            ffi_d = idx_q;
          end
        end
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRIVE;
          idx_d   = idx_q + 4'd1;
          // The next vector's value is the LSB of idx+1, i.e. the inverted LSB.
          dut_a_d = ~idx_q[0];
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= 4'd0;
      settle_q <= 4'd0;
      dut_a_q  <= 1'b0;
      err_q    <= '0;
      fv_q     <= 1'b0;
      ffi_q    <= 4'd0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      settle_q <= settle_d;
      dut_a_q  <= dut_a_d;
      err_q    <= err_d;
      fv_q     <= fv_d;
      ffi_q    <= ffi_d;
    end
  end

  // All outputs are decoded from registers only; dut_out never reaches them
  // combinationally.
  assign dut_a          = dut_a_q;
  assign busy           = (state_q == ST_DRIVE) || (state_q == ST_SETTLE) ||
                          (state_q == ST_CHECK);
  assign done           = (state_q == ST_DONE);
  assign pass           = done && (err_q == '0);
  assign err_cnt        = err_q;
  assign fail_valid     = fv_q;
  assign first_fail_idx = ffi_q;

endmodule

// File: tb/tb_not_bist_ctrl.sv
// ---------------------------------------------------------------------------
// tb_not_bist_ctrl
//   Two controller instances: default parameters (u0) and a long, fast,
//   narrow-counter variant (u1: 16 vectors, SETTLE=0, CNT_W=3). A behavioural
//   model of the device under test (inverter / stuck / buffer) feeds dut_out.
//   Expected run results and dut_a vectors are queued when start is driven and
//   popped as the controller produces them.
// ---------------------------------------------------------------------------
module tb_not_bist_ctrl;

  localparam int NV0 = 6,  S0 = 2, CW0 = 4;
  localparam int NV1 = 16, S1 = 0, CW1 = 3;

  localparam int M_INV = 0, M_ST0 = 1, M_ST1 = 2, M_BUF = 3;

  typedef struct {
    int err;
    int pass;
    int fv;
    int ffi;
    int lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start0 = 1'b0, start1 = 1'b0;
  int   mode0 = M_INV, mode1 = M_INV;

  logic           dut_a0, dut_out0, busy0, done0, pass0, fv0;
  logic [CW0-1:0] err0;
  logic [3:0]     ffi0;
  logic           dut_a1, dut_out1, busy1, done1, pass1, fv1;
  logic [CW1-1:0] err1;
  logic [3:0]     ffi1;

  int n_cmp = 0;
  int n_bad = 0;

  exp_t exp_q[$];
  int   a_q[$];

  always #5 clk = ~clk;

  function automatic logic model_out(input int mode, input logic a);
    case (mode)
      M_ST0:   return 1'b0;
      M_ST1:   return 1'b1;
      M_BUF:   return a;
      default: return ~a;
    endcase
  endfunction

  assign dut_out0 = model_out(mode0, dut_a0);
  assign dut_out1 = model_out(mode1, dut_a1);

  not_bist_ctrl #(.NUM_VECTORS(NV0), .SETTLE(S0), .CNT_W(CW0)) u0 (
    .clk(clk), .rst(rst), .start(start0), .dut_a(dut_a0), .dut_out(dut_out0),
    .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0),
    .fail_valid(fv0), .first_fail_idx(ffi0)
  );

  not_bist_ctrl #(.NUM_VECTORS(NV1), .SETTLE(S1), .CNT_W(CW1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .dut_a(dut_a1), .dut_out(dut_out1),
    .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1),
    .fail_valid(fv1), .first_fail_idx(ffi1)
  );

  task automatic check_val(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Observed-signal selectors so one run task serves both instances.
  function automatic int o_busy(input int w); return (w == 0) ? int'(busy0) : int'(busy1); endfunction
  function automatic int o_done(input int w); return (w == 0) ? int'(done0) : int'(done1); endfunction
  function automatic int o_pass(input int w); return (w == 0) ? int'(pass0) : int'(pass1); endfunction
  function automatic int o_err(input int w);  return (w == 0) ? int'(err0)  : int'(err1);  endfunction
  function automatic int o_fv(input int w);   return (w == 0) ? int'(fv0)   : int'(fv1);   endfunction
  function automatic int o_ffi(input int w);  return (w == 0) ? int'(ffi0)  : int'(ffi1);  endfunction
  function automatic int o_a(input int w);    return (w == 0) ? int'(dut_a0) : int'(dut_a1); endfunction

  // Builds the expected run result from the device model and pushes it, along
  // with the dut_a value of every vector.
  task automatic push_expected(input int w, input int mode);
    exp_t e;
    int nv, st, emax;
    logic a, o;
    nv   = (w == 0) ? NV0 : NV1;
    st   = (w == 0) ? S0 : S1;
    emax = (w == 0) ? (1 << CW0) - 1 : (1 << CW1) - 1;
    e.err = 0; e.fv = 0; e.ffi = 0; e.lat = nv * (st + 2);
    for (int k = 0; k < nv; k++) begin
      a = 1'(k & 1);
      a_q.push_back(int'(a));
      o = model_out(mode, a);
      if (o != ~a) begin
        if (e.err < emax) e.err++;
        if (e.fv == 0) begin
          e.fv  = 1;
          e.ffi = k;
        end
      end
    end
    e.pass = (e.err == 0) ? 1 : 0;
    exp_q.push_back(e);
  endtask

  task automatic drive_start(input int w, input logic v);
    if (w == 0) start0 = v; else start1 = v;
  endtask

  // One full run: start pulsed (or held), dut_a checked at each vector's
  // DRIVE, then latency and result checked against the popped expectation.
  task automatic run(input int w, input int mode, input bit hold);
    exp_t e;
    int n, per, limit;
    per = (w == 0) ? S0 + 2 : S1 + 2;
    if (w == 0) mode0 = mode; else mode1 = mode;
    push_expected(w, mode);
    limit = exp_q[$].lat + 10;
    @(negedge clk);
    drive_start(w, 1'b1);
    @(posedge clk); #1;
    if (!hold) drive_start(w, 1'b0);
    check_val("clr_err", o_err(w), 0);
    check_val("clr_fv", o_fv(w), 0);
    n = 0;
    while (o_done(w) == 0 && n <= limit) begin
      if (n % per == 0 && a_q.size() > 0) check_val("dut_a", o_a(w), a_q.pop_front());
      if (o_pass(w) != 0) check_val("pass_busy", o_pass(w), 0);
      @(posedge clk); #1;
      n++;
    end
    e = exp_q.pop_front();
    if (n > limit) check_val("timeout", 0, 1);
    check_val("latency", n, e.lat);
    check_val("vec_count", a_q.size(), 0);
    a_q.delete();
    check_val("busy_done", o_busy(w), 0);
    check_val("err_cnt", o_err(w), e.err);
    check_val("pass", o_pass(w), e.pass);
    check_val("fail_valid", o_fv(w), e.fv);
    check_val("first_fail", o_ffi(w), e.ffi);
    $display("run inst=%0d mode=%0d lat=%0d err=%0d pass=%0d fv=%0d ffi=%0d",
             w, mode, n, o_err(w), o_pass(w), o_fv(w), o_ffi(w));
  endtask

  initial begin
    int seen_done;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("rst_busy", int'(busy0), 0);
    check_val("rst_done", int'(done0), 0);
    check_val("rst_pass", int'(pass0), 0);
    check_val("rst_err", int'(err0), 0);
    check_val("rst_dut_a", int'(dut_a0), 0);
    check_val("rst_fv", int'(fv0), 0);

    run(0, M_INV, 1'b0);
    run(0, M_ST0, 1'b0);  // restarts from DONE

    // DONE holds its results while start stays low.
    repeat (3) @(posedge clk);
    #1;
    check_val("hold_done", int'(done0), 1);
    check_val("hold_err", int'(err0), 3);
    check_val("hold_ffi", int'(ffi0), 0);
    check_val("hold_dut_a", int'(dut_a0), 1);

    run(0, M_ST1, 1'b0);
    run(1, M_BUF, 1'b0);  // saturates the 3-bit counter

    // start held high for the whole run: no restart until DONE, then restart.
    run(1, M_INV, 1'b1);
    @(posedge clk); #1;
    check_val("restart_busy", int'(busy1), 1);
    check_val("restart_done", int'(done1), 0);
    check_val("restart_a", int'(dut_a1), 0);
    start1 = 1'b0;

    // Abort during SETTLE of vector 3 with partial errors accumulated.
    mode0 = M_ST0;
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    repeat (13) begin
      @(posedge clk); #1;
    end
    check_val("mid_busy", int'(busy0), 1);
    check_val("mid_err", int'(err0), 2);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_val("abort_busy", int'(busy0), 0);
    check_val("abort_done", int'(done0), 0);
    check_val("abort_err", int'(err0), 0);
    check_val("abort_fv", int'(fv0), 0);
    check_val("abort_ffi", int'(ffi0), 0);
    check_val("abort_dut_a", int'(dut_a0), 0);
    seen_done = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done0 || busy0) seen_done = 1;
    end
    check_val("abort_idle", seen_done, 0);
    $display("abort run checked");

    run(0, M_INV, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
